// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory handshake, redirect input and decode-side queue head.
interface fetch_prefetch_queue_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_ack, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_ack, mem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetcher: issues word-aligned fetches to a variable-latency memory and
// queues returned words with their PCs; a redirect flushes the queue and restarts fetch.
//
// state | meaning
// IDLE  | no request outstanding
// WAIT  | request outstanding, returned word will be queued
// DROP  | request outstanding, returned word belongs to a flushed path and is discarded
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic              clock,
    input logic              reset_n,
    fetch_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          ack;
    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;
    logic [31:0]   pc_eff;
    logic          busy_after;
    logic          issue;

    assign ack        = bus.mem_req & bus.mem_ack;
    assign push       = ack & (state == WAIT) & ~bus.redirect_valid;
    assign pop        = bus.instr_valid & bus.instr_ready & ~bus.redirect_valid;
    assign count_next = bus.redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    assign pc_eff     = bus.redirect_valid ? (bus.redirect_pc & 32'hFFFF_FFFC) : fetch_pc;
    // A request still in flight after this edge blocks issue; its slot was reserved at issue time.
    assign busy_after = (state != IDLE) && !ack;
    assign issue      = !busy_after && (count_next < CW'(DEPTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= RESET_PC;
            fetch_pc     <= RESET_PC;
        end else if (busy_after) begin
            if (bus.redirect_valid)
                state <= DROP;
            fetch_pc <= pc_eff;
        end else if (issue) begin
            state        <= WAIT;
            bus.mem_req  <= 1'b1;
            bus.mem_addr <= pc_eff;
            fetch_pc     <= pc_eff + 32'd4;
        end else begin
            state       <= IDLE;
            bus.mem_req <= 1'b0;
            fetch_pc    <= pc_eff;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr] <= bus.mem_rdata;
            pc_q[wr_ptr]   <= bus.mem_addr;
        end
    end

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = bus.instr_valid ? data_q[rd_ptr] : 32'h0;
    assign bus.instr_pc    = bus.instr_valid ? pc_q[rd_ptr]   : 32'h0;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: streaming, backpressure, redirects, wrap and reset.
module tb_fetch_prefetch_queue;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic auto_data = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   ack_count = 0;

    fetch_prefetch_queue_if bus();

    fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic tick;
        if (bus.mem_req && bus.mem_ack) ack_count++;
        @(posedge clock);
        #1;
        if (auto_data) bus.mem_rdata = mem_word(bus.mem_addr);
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        auto_data = 1'b1;
        bus.mem_ack = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.instr_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        tick();
        reset_n = 1'b1;
        ack_count = 0;
    endtask

    task automatic test_reset;
        do_reset();
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0b want 0", bus.mem_req); end
        n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %0b want 0", bus.instr_valid); end
        n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", bus.instr); end
        n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_instr_pc got %h want 0", bus.instr_pc); end
    endtask

    task automatic test_stream;
        do_reset();
        bus.mem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL stream_first_req got req=%0b addr=%h want 1/0", bus.mem_req, bus.mem_addr); end
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid got %0b want 0", bus.instr_valid); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (bus.mem_addr !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL stream_addr[%0d] got %h want %h", i, bus.mem_addr, 32'(4 * (i + 1))); end
            n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d] got v=%0b pc=%h want 1/%h", i, bus.instr_valid, bus.instr_pc, 32'(4 * i)); end
            n_checks++; if (bus.instr !== mem_word(32'(4 * i))) begin n_fail++; $display("FAIL stream_instr[%0d] got %h want %h", i, bus.instr, mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (ack_count !== 4) begin n_fail++; $display("FAIL bp_ack_count got %0d want 4", ack_count); end
        n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_idle got %0b want 0", bus.mem_req); end
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head got v=%0b pc=%h want 1/0", bus.instr_valid, bus.instr_pc); end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL bp_one_req got req=%0b addr=%h want 1/10", bus.mem_req, bus.mem_addr); end
        n_checks++; if (bus.instr_pc !== 32'h4) begin n_fail++; $display("FAIL bp_pop_head got %h want 4", bus.instr_pc); end
        for (int i = 0; i < 6; i++) tick();
        n_checks++; if (ack_count !== 5 || bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_refill got acks=%0d req=%0b want 5/0", ack_count, bus.mem_req); end
    endtask

    task automatic test_redirect_latency;
        do_reset();
        auto_data = 1'b0;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h10;
        tick();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL rl_req10 got req=%0b addr=%h want 1/10", bus.mem_req, bus.mem_addr); end
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL rl_hold got req=%0b addr=%h want 1/10", bus.mem_req, bus.mem_addr); end
        tick();
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hDEAD_0010;
        tick();
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rl_dropped got valid=%0b instr=%h want 0", bus.instr_valid, bus.instr); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40) begin n_fail++; $display("FAIL rl_req40 got req=%0b addr=%h want 1/40", bus.mem_req, bus.mem_addr); end
        bus.mem_rdata = 32'h1234_0040;
        tick();
        bus.mem_ack = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.instr !== 32'h1234_0040) begin n_fail++; $display("FAIL rl_first got v=%0b pc=%h instr=%h want 1/40/12340040", bus.instr_valid, bus.instr_pc, bus.instr); end
        n_checks++; if (bus.mem_addr !== 32'h44) begin n_fail++; $display("FAIL rl_next_addr got %h want 44", bus.mem_addr); end
    endtask

    task automatic test_redirect_same_edge;
        do_reset();
        bus.mem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        tick();
        tick();
        n_checks++; if (bus.mem_addr !== 32'h8 || bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4) begin n_fail++; $display("FAIL rs_setup got addr=%h v=%0b pc=%h want 8/1/4", bus.mem_addr, bus.instr_valid, bus.instr_pc); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h203;
        tick();
        bus.redirect_valid = 1'b0;
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rs_flush got %0b want 0", bus.instr_valid); end
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin n_fail++; $display("FAIL rs_new_addr got req=%0b addr=%h want 1/200", bus.mem_req, bus.mem_addr); end
        tick();
        n_checks++; if (bus.instr_pc !== 32'h200 || bus.mem_addr !== 32'h204) begin n_fail++; $display("FAIL rs_restart got pc=%h addr=%h want 200/204", bus.instr_pc, bus.mem_addr); end
    endtask

    task automatic test_wrap;
        logic [31:0] exp_addr [4];
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
        do_reset();
        bus.mem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.redirect_valid = 1'b0;
            n_checks++; if (bus.mem_addr !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got %h want %h", i, bus.mem_addr, exp_addr[i]); end
        end
        n_checks++; if (bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_instr_pc got %h want 0", bus.instr_pc); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        tick();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h4 || bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rm_setup got req=%0b addr=%h v=%0b want 1/4/1", bus.mem_req, bus.mem_addr, bus.instr_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async got req=%0b v=%0b want 0/0", bus.mem_req, bus.instr_valid); end
        bus.mem_ack = 1'b1;
        tick();
        reset_n = 1'b1;
        ack_count = 0;
        tick();
        n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_restart got req=%0b addr=%h v=%0b want 1/0/0", bus.mem_req, bus.mem_addr, bus.instr_valid); end
        tick();
        n_checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin n_fail++; $display("FAIL rm_first got v=%0b pc=%h want 1/0", bus.instr_valid, bus.instr_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_same_edge();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
